// File: rtl/down_counter_ld_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_pkg
//   Shared types and constants for the loadable down-counter/timer
//   (down_counter_ld). Imported by the interface and the top module.
//
//   dc_state_t        : two-state controller encoding (IDLE / RUN), 1 bit
//   DC_WIDTH_DEFAULT  : default count/load width
//   dc_is_zero()      : helper used to classify a load as a zero-length timer
// -----------------------------------------------------------------------------
package down_counter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } dc_state_t;

   localparam int DC_WIDTH_DEFAULT = 4;

   // Reduction over an arbitrary-width vector; callers pass the load value
   // zero-extended into 32 bits so a single function serves every WIDTH.
   function automatic logic dc_is_zero(input logic [31:0] v);
      return (v == 32'd0);
   endfunction

endpackage : down_counter_pkg

// File: rtl/down_counter_ld_if.sv
// -----------------------------------------------------------------------------
// down_counter_ld_if
//   Groups the load handshake, count control and status signals of the
//   loadable down-counter. CLK/RESET stay as plain ports on the module.
//
//   LOAD_VALID  load request                          (master -> slave)
//   LOAD_VAL    start value, sampled on handshake     (master -> slave)
//   LOAD_READY  block can accept a load               (slave  -> master)
//   CE          count enable                          (master -> slave)
//   ABORT       cancel the current count              (master -> slave)
//   O           current count, registered            (slave  -> master)
//   BUSY        high while counting                   (slave  -> master)
//   DONE        one-cycle terminal-count pulse        (slave  -> master)
//
//   Modports: master = the user of the timer, slave = the timer itself.
// -----------------------------------------------------------------------------
interface down_counter_ld_if
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DC_WIDTH_DEFAULT
);

   logic             LOAD_VALID;
   logic [WIDTH-1:0] LOAD_VAL;
   logic             LOAD_READY;
   logic             CE;
   logic             ABORT;
   logic [WIDTH-1:0] O;
   logic             BUSY;
   logic             DONE;

   modport master (
      output LOAD_VALID,
      output LOAD_VAL,
      input  LOAD_READY,
      output CE,
      output ABORT,
      input  O,
      input  BUSY,
      input  DONE
   );

   modport slave (
      input  LOAD_VALID,
      input  LOAD_VAL,
      output LOAD_READY,
      input  CE,
      input  ABORT,
      output O,
      output BUSY,
      output DONE
   );

endinterface : down_counter_ld_if

// File: rtl/down_counter_ld.sv
// -----------------------------------------------------------------------------
// down_counter_ld
//   Loadable down-counter / programmable timeout. A start value is accepted
//   over a valid/ready handshake, the count decrements once per cycle with CE
//   high, and DONE pulses for one cycle when the count reaches zero. Count-down
//   counterpart of the free-running up-counter in the counter build.
//
//   Ports:
//     CLK    rising-edge clock (only clock)
//     RESET  synchronous, active-high; overrides every other input
//     bus    down_counter_ld_if.slave (LOAD_VALID/LOAD_VAL/LOAD_READY,
//            CE, ABORT, O, BUSY, DONE)
//
//   Parameter:
//     WIDTH  bit width of count and load value (>= 2)
//
//   Build option:
//     COUNTDOWN_AUTO_RELOAD_EN  when defined, terminal count reloads the last
//                               loaded value and keeps running, so DONE pulses
//                               once per period until ABORT or RESET. When
//                               undefined the timer is one-shot and the reload
//                               register is written but never read back.
//
//   Timing: a load of N with CE held high puts DONE high N cycles after the
//   handshake edge; LOAD_READY is high again in that same cycle so a new load
//   can be issued back-to-back. A load of zero gives DONE on the next cycle
//   without ever entering RUN.
// -----------------------------------------------------------------------------
module down_counter_ld
   import down_counter_pkg::*;
#(
   parameter int WIDTH = DC_WIDTH_DEFAULT
) (
   input  logic                CLK,
   input  logic                RESET,
   down_counter_ld_if.slave    bus
);

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Decrement that floors at zero. The controller only calls it with a count
   // above one, so the floor never engages in normal operation; it exists so
   // the datapath can never wrap to all-ones whatever the control does.
   function automatic logic [WIDTH-1:0] dec_floor(input logic [WIDTH-1:0] v);
      return (v == '0) ? '0 : v - CNT_ONE;
   endfunction

   dc_state_t        state_p0,  state_nxt;
   logic [WIDTH-1:0] count_p0,  count_nxt;
   logic [WIDTH-1:0] reload_p0, reload_nxt;
   logic             done_p0,   done_nxt;

   logic             load_ready;
   logic             load_fire;
   logic             load_is_zero;

   // LOAD_READY is the only combinational output; it drops in the reset cycle
   // so a load presented together with RESET is never seen as accepted.
   assign load_ready   = (state_p0 == IDLE) && !RESET;
   assign load_fire    = bus.LOAD_VALID && load_ready;
   assign load_is_zero = dc_is_zero(32'(bus.LOAD_VAL));

   always_comb begin
      state_nxt  = state_p0;
      count_nxt  = count_p0;
      reload_nxt = reload_p0;
      done_nxt   = 1'b0;

      case (state_p0)
         IDLE: begin
            // CE and ABORT have no meaning until a count is running.
            if (load_fire) begin
               if (load_is_zero) begin
                  // Zero-length timer: signal completion, never go busy.
                  done_nxt = 1'b1;
               end else begin
                  count_nxt  = bus.LOAD_VAL;
                  reload_nxt = bus.LOAD_VAL;
                  state_nxt  = RUN;
               end
            end
         end

         RUN: begin
            if (bus.ABORT) begin
               // Cancel wins over a simultaneous terminal count: no DONE.
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (bus.CE) begin
               // Terminal check comes before the decrement, so the count
               // lands exactly on zero and never wraps.
               if (count_p0 > CNT_ONE) begin
                  count_nxt = dec_floor(count_p0);
               end else begin
                  done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  count_nxt = reload_p0;
`else
                  count_nxt = '0;
                  state_nxt = IDLE;
`endif
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
         end
      endcase
   end

   // ---- register stage: controller state, count, reload value, DONE ----
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_p0  <= IDLE;
         count_p0  <= '0;
         reload_p0 <= '0;
         done_p0   <= 1'b0;
      end else begin
         state_p0  <= state_nxt;
         count_p0  <= count_nxt;
         reload_p0 <= reload_nxt;
         done_p0   <= done_nxt;
      end
   end

   assign bus.LOAD_READY = load_ready;
   assign bus.O          = count_p0;
   assign bus.BUSY       = (state_p0 == RUN);
   assign bus.DONE       = done_p0;

endmodule : down_counter_ld

// File: tb/tb_down_counter_ld.sv
module tb_down_counter_ld;

   localparam int W = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   down_counter_ld_if #(.WIDTH(W)) bus ();

   down_counter_ld #(.WIDTH(W)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input int v);
      bus.LOAD_VAL   = W'(v);
      bus.LOAD_VALID = 1'b1;
      tick();
      bus.LOAD_VALID = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.LOAD_VALID = 1'b1;
      bus.LOAD_VAL   = 4'd7;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_tests++;
         if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.LOAD_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got O=%0d BUSY=%b DONE=%b RDY=%b expected 0 0 0 0",
                     bus.O, bus.BUSY, bus.DONE, bus.LOAD_READY);
         end
      end
      bus.LOAD_VALID = 1'b0;
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.LOAD_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b expected 1", bus.LOAD_READY);
      end
   endtask

   task automatic test_one_shot();
      logic [W-1:0] eo;
      bus.CE = 1'b1;
      drive_load(5);
      n_tests++;
      if (bus.O !== 4'd5 || bus.BUSY !== 1'b1 || bus.LOAD_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL one_shot_load: got O=%0d BUSY=%b RDY=%b expected 5 1 0", bus.O, bus.BUSY, bus.LOAD_READY);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         eo = W'(5 - k);
         n_tests++;
         if (bus.O !== eo || bus.DONE !== (k == 5) || bus.BUSY !== (k != 5) || bus.LOAD_READY !== (k == 5)) begin
            n_fail++;
            $display("FAIL one_shot_cycle%0d: got O=%0d DONE=%b BUSY=%b RDY=%b expected O=%0d DONE=%b BUSY=%b RDY=%b",
                     k, bus.O, bus.DONE, bus.BUSY, bus.LOAD_READY, eo, (k == 5), (k != 5), (k == 5));
         end
      end
      tick();
      n_tests++;
      if (bus.DONE !== 1'b0 || bus.O !== 4'd0) begin
         n_fail++;
         $display("FAIL one_shot_after: got DONE=%b O=%0d expected 0 0", bus.DONE, bus.O);
      end
      bus.CE = 1'b0;
   endtask

   task automatic test_ce_gating();
      logic       ce_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [3:0] o_exp  [5] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
      drive_load(3);
      for (int k = 0; k < 5; k++) begin
         bus.CE = ce_pat[k];
         tick();
         n_tests++;
         if (bus.O !== o_exp[k] || bus.DONE !== (k == 4)) begin
            n_fail++;
            $display("FAIL ce_gating_step%0d: got O=%0d DONE=%b expected O=%0d DONE=%b",
                     k, bus.O, bus.DONE, o_exp[k], (k == 4));
         end
      end
      bus.CE = 1'b0;
      tick();
   endtask

   task automatic test_zero_load();
      bus.CE = 1'b1;
      drive_load(0);
      n_tests++;
      if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.O !== 4'd0 || bus.LOAD_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_load: got DONE=%b BUSY=%b O=%0d RDY=%b expected 1 0 0 1",
                  bus.DONE, bus.BUSY, bus.O, bus.LOAD_READY);
      end
      tick();
      n_tests++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_load_after: got DONE=%b BUSY=%b expected 0 0", bus.DONE, bus.BUSY);
      end
      bus.CE = 1'b0;
   endtask

   task automatic test_abort();
      bus.CE = 1'b1;
      drive_load(15);
      for (int k = 0; k < 3; k++) tick();
      n_tests++;
      if (bus.O !== 4'd12) begin
         n_fail++;
         $display("FAIL abort_pre: got O=%0d expected 12", bus.O);
      end
      bus.ABORT = 1'b1;
      tick();
      bus.ABORT = 1'b0;
      n_tests++;
      if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.LOAD_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL abort: got O=%0d BUSY=%b DONE=%b RDY=%b expected 0 0 0 1",
                  bus.O, bus.BUSY, bus.DONE, bus.LOAD_READY);
      end
      tick();
      n_tests++;
      if (bus.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: got %b expected 0", bus.DONE);
      end
      bus.CE = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.CE = 1'b1;
      drive_load(15);
      for (int k = 0; k < 5; k++) tick();
      n_tests++;
      if (bus.O !== 4'd10 || bus.BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got O=%0d BUSY=%b expected 10 1", bus.O, bus.BUSY);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.LOAD_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got O=%0d BUSY=%b DONE=%b RDY=%b expected 0 0 0 0",
                  bus.O, bus.BUSY, bus.DONE, bus.LOAD_READY);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.DONE !== 1'b0 || bus.O !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_mid_after: got DONE=%b O=%0d expected 0 0", bus.DONE, bus.O);
      end
      bus.CE = 1'b0;
   endtask

   task automatic test_max_back_to_back();
      logic [W-1:0] eo;
      bus.CE = 1'b1;
      drive_load(15);
      for (int k = 1; k <= 14; k++) begin
         tick();
         eo = W'(15 - k);
         n_tests++;
         if (bus.O !== eo || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL max_count_cycle%0d: got O=%0d DONE=%b expected O=%0d DONE=0", k, bus.O, bus.DONE, eo);
         end
      end
      bus.LOAD_VAL   = 4'd2;
      bus.LOAD_VALID = 1'b1;
      tick();
      n_tests++;
      if (bus.O !== 4'd0 || bus.DONE !== 1'b1 || bus.LOAD_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL max_done: got O=%0d DONE=%b RDY=%b BUSY=%b expected 0 1 1 0",
                  bus.O, bus.DONE, bus.LOAD_READY, bus.BUSY);
      end
      tick();
      bus.LOAD_VALID = 1'b0;
      n_tests++;
      if (bus.O !== 4'd2 || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_load: got O=%0d BUSY=%b DONE=%b expected 2 1 0", bus.O, bus.BUSY, bus.DONE);
      end
      tick();
      tick();
      n_tests++;
      if (bus.O !== 4'd0 || bus.DONE !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done: got O=%0d DONE=%b expected 0 1", bus.O, bus.DONE);
      end
      bus.CE = 1'b0;
      tick();
   endtask

   task automatic test_auto_reload();
      logic [W-1:0] eo;
      bus.CE = 1'b1;
      drive_load(3);
      for (int k = 1; k <= 10; k++) begin
         tick();
         eo = W'(3 - (k % 3));
         n_tests++;
         if (bus.O !== eo || bus.DONE !== ((k % 3) == 0) || bus.LOAD_READY !== 1'b0 || bus.BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_cycle%0d: got O=%0d DONE=%b RDY=%b BUSY=%b expected O=%0d DONE=%b RDY=0 BUSY=1",
                     k, bus.O, bus.DONE, bus.LOAD_READY, bus.BUSY, eo, ((k % 3) == 0));
         end
      end
      bus.ABORT = 1'b1;
      tick();
      bus.ABORT = 1'b0;
      n_tests++;
      if (bus.O !== 4'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.LOAD_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL auto_abort: got O=%0d BUSY=%b DONE=%b RDY=%b expected 0 0 0 1",
                  bus.O, bus.BUSY, bus.DONE, bus.LOAD_READY);
      end
      drive_load(0);
      n_tests++;
      if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL auto_zero_load: got DONE=%b BUSY=%b expected 1 0", bus.DONE, bus.BUSY);
      end
      tick();
      n_tests++;
      if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL auto_zero_after: got DONE=%b BUSY=%b expected 0 0", bus.DONE, bus.BUSY);
      end
      bus.CE = 1'b0;
   endtask

   // Reference: a timer either is idle or has "left" enabled cycles to go
   // until completion; completion raises DONE for the following cycle.
   task automatic test_random();
      bit m_run;
      int m_left;
      int m_period;
      bit m_done;
      bit lv, ce, ab, r;
      int val;
      logic [W-1:0] eo;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_run = 0; m_left = 0; m_period = 0; m_done = 0;
      for (int i = 0; i < 1500; i++) begin
         lv  = ($urandom % 3) == 0;
         val = (($urandom % 8) == 0) ? 0 : int'($urandom % 16);
         ce  = ($urandom % 4) != 0;
         ab  = ($urandom % 24) == 0;
         r   = ($urandom % 90) == 0;
         bus.LOAD_VALID = lv;
         bus.LOAD_VAL   = W'(val);
         bus.CE         = ce;
         bus.ABORT      = ab;
         rst            = r;
         #1;
         n_tests++;
         if (bus.LOAD_READY !== (!m_run && !r)) begin
            n_fail++;
            $display("FAIL rand_ready@%0d: got %b expected %b", i, bus.LOAD_READY, (!m_run && !r));
         end
         @(posedge clk);
         #1;
         if (r) begin
            m_run = 0; m_left = 0; m_period = 0; m_done = 0;
         end else if (!m_run) begin
            m_done = lv && (val == 0);
            if (lv && val != 0) begin
               m_run = 1; m_left = val; m_period = val;
            end
         end else begin
            m_done = 0;
            if (ab) begin
               m_run = 0; m_left = 0;
            end else if (ce) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  m_left = m_period;
`else
                  m_run = 0;
`endif
               end
            end
         end
         eo = W'(m_left);
         n_tests++;
         if (bus.O !== eo || bus.BUSY !== m_run || bus.DONE !== m_done) begin
            n_fail++;
            $display("FAIL rand_out@%0d: got O=%0d BUSY=%b DONE=%b expected O=%0d BUSY=%b DONE=%b",
                     i, bus.O, bus.BUSY, bus.DONE, eo, m_run, m_done);
         end
      end
      bus.LOAD_VALID = 1'b0;
      bus.CE         = 1'b0;
      bus.ABORT      = 1'b0;
      rst            = 1'b0;
   endtask

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      rst            = 1'b1;
      bus.LOAD_VALID = 1'b0;
      bus.LOAD_VAL   = '0;
      bus.CE         = 1'b0;
      bus.ABORT      = 1'b0;
      test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      test_auto_reload();
`else
      test_one_shot();
      test_ce_gating();
      test_zero_load();
      test_abort();
      test_reset_mid();
      test_max_back_to_back();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_down_counter_ld
